// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : MIPS instruction-fetch stage (PC, imem address, IF/ID register)
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemInstr,
    output logic [31:0] pc,
    output logic [31:0] ifidInstr,
    output logic [31:0] ifidPcPlus4,
    output logic        ifidValid,
    output logic [31:0] fetchCount
);

    localparam logic [1:0] MODE_RESET = 2'd0;
    localparam logic [1:0] MODE_HOLD  = 2'd1;
    localparam logic [1:0] MODE_FLUSH = 2'd2;
    localparam logic [1:0] MODE_RUN   = 2'd3;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;

    logic [1:0]  w_mode;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target_aligned;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_target_aligned = {redirectTarget[31:2], 2'b00};

    // A stalled branch's redirect is provisional, so stall outranks redirect.
    always_comb begin
        w_mode = MODE_RUN;
        if (reset)
            w_mode = MODE_RESET;
        else if (stall)
            w_mode = MODE_HOLD;
        else if (redirect)
            w_mode = MODE_FLUSH;
    end

    always_ff @(posedge clk) begin
        case (w_mode)
            MODE_RESET: begin
                r_pc            <= RESET_PC;
                r_ifid_instr    <= NOP;
                r_ifid_pc_plus4 <= 32'd0;
                r_ifid_valid    <= 1'b0;
                r_fetch_count   <= 32'd0;
            end
            MODE_HOLD: begin
                r_pc            <= r_pc;
                r_ifid_instr    <= r_ifid_instr;
                r_ifid_pc_plus4 <= r_ifid_pc_plus4;
                r_ifid_valid    <= r_ifid_valid;
                r_fetch_count   <= r_fetch_count;
            end
            MODE_FLUSH: begin
                r_pc            <= w_target_aligned;
                r_ifid_instr    <= NOP;
                r_ifid_pc_plus4 <= 32'd0;
                r_ifid_valid    <= 1'b0;
                r_fetch_count   <= r_fetch_count;
            end
            default: begin
                r_pc            <= w_pc_plus4;
                r_ifid_instr    <= imemInstr;
                r_ifid_pc_plus4 <= w_pc_plus4;
                r_ifid_valid    <= 1'b1;
                r_fetch_count   <= r_fetch_count + 32'd1;
            end
        endcase
    end

    assign imemAddr    = r_pc;
    assign pc          = r_pc;
    assign ifidInstr   = r_ifid_instr;
    assign ifidPcPlus4 = r_ifid_pc_plus4;
    assign ifidValid   = r_ifid_valid;
    assign fetchCount  = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed vector bench for fetch_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (RESET_PC = 0)
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectTarget = 32'd0;
    logic [31:0] imemAddr, imemInstr, pc, ifidInstr, ifidPcPlus4, fetchCount;
    logic        ifidValid;

    // Wrap instance (RESET_PC at top of address space)
    logic        w_reset = 1'b1;
    logic [31:0] w_imemAddr, w_imemInstr, w_pc, w_ifidInstr, w_ifidPcPlus4, w_fetchCount;
    logic        w_ifidValid;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory image: words 0..15 hold (idx+1)*0x11, everything else DEAD_<idx>
    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        logic [29:0] idx;
        idx = addr[31:2];
        if (idx < 30'd16)
            return 32'(idx + 30'd1) * 32'h11;
        else
            return {16'hDEAD, idx[15:0]};
    endfunction

    assign imemInstr   = instr_of(imemAddr);
    assign w_imemInstr = instr_of(w_imemAddr);

    fetch_unit u_dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirectTarget(redirectTarget), .imemAddr(imemAddr), .imemInstr(imemInstr),
        .pc(pc), .ifidInstr(ifidInstr), .ifidPcPlus4(ifidPcPlus4),
        .ifidValid(ifidValid), .fetchCount(fetchCount)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(w_reset), .stall(1'b0), .redirect(1'b0),
        .redirectTarget(32'd0), .imemAddr(w_imemAddr), .imemInstr(w_imemInstr),
        .pc(w_pc), .ifidInstr(w_ifidInstr), .ifidPcPlus4(w_ifidPcPlus4),
        .ifidValid(w_ifidValid), .fetchCount(w_fetchCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_p4, input logic e_valid, input logic [31:0] e_cnt);
        check({tag, ".pc"},       pc,          e_pc);
        check({tag, ".imemAddr"}, imemAddr,    e_pc);
        check({tag, ".instr"},    ifidInstr,   e_instr);
        check({tag, ".pcp4"},     ifidPcPlus4, e_p4);
        check({tag, ".valid"},    32'(ifidValid), 32'(e_valid));
        check({tag, ".count"},    fetchCount,  e_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_p4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [12];

    initial begin
        //            stall rd  target        pc            instr         p4            v     cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  32'h04, 32'h11,        32'h04, 1'b1, 32'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h08, 32'h22,        32'h08, 1'b1, 32'd2};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  32'h08, 32'h22,        32'h08, 1'b1, 32'd2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  32'h08, 32'h22,        32'h08, 1'b1, 32'd2};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h0C, 32'h33,        32'h0C, 1'b1, 32'd3};
        vecs[5]  = '{1'b0, 1'b1, 32'h20, 32'h20, 32'h0,         32'h0,  1'b0, 32'd3};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  32'h24, 32'h99,        32'h24, 1'b1, 32'd4};
        vecs[7]  = '{1'b1, 1'b1, 32'h40, 32'h24, 32'h99,        32'h24, 1'b1, 32'd4};
        vecs[8]  = '{1'b0, 1'b1, 32'h40, 32'h40, 32'h0,         32'h0,  1'b0, 32'd4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  32'h44, 32'hDEAD_0010, 32'h44, 1'b1, 32'd5};
        vecs[10] = '{1'b0, 1'b1, 32'h4B, 32'h48, 32'h0,         32'h0,  1'b0, 32'd5};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  32'h4C, 32'hDEAD_0012, 32'h4C, 1'b1, 32'd6};

        // Reset state
        step();
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            stall          = vecs[i].stall;
            redirect       = vecs[i].redirect;
            redirectTarget = vecs[i].target;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                        vecs[i].e_p4, vecs[i].e_valid, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Reset mid-stream wins over stall and redirect
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirectTarget = 32'h80;
        step();
        check_state("midreset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        step();
        check_state("postreset", 32'h04, 32'h11, 32'h04, 1'b1, 32'd1);

        // PC wrap from 0xFFFF_FFFC
        @(negedge clk);
        check("wrap.reset_pc", w_pc, 32'hFFFF_FFFC);
        w_reset = 1'b0;
        step();
        check("wrap.pc",    w_pc,          32'h0);
        check("wrap.pcp4",  w_ifidPcPlus4, 32'h0);
        check("wrap.instr", w_ifidInstr,   32'hDEAD_FFFF);
        check("wrap.valid", 32'(w_ifidValid), 32'd1);
        check("wrap.count", w_fetchCount,  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
